// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the multiplexed bus cycle sequencer
package bus_pkg;

  localparam int BUS_W  = 8;
  localparam int ADDR_W = 16;

  localparam logic [BUS_W-1:0] RD_DATA_ON_ERR = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3
  } bus_state_e;

  // Strobe phase of a cycle: the bus owns the data lines from T2 until T3 ends.
  function automatic logic in_data_phase(input bus_state_e s);
    return (s == T2) || (s == TW) || (s == T3);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - saturating count of TW states with a timeout flag at WAIT_LIMIT
module bus_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] count;

  // Saturates rather than wraps so an unlimited wait never aliases to a small count.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = (WAIT_LIMIT != 0) && (count == CNT_LIMIT);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - T1/T2/TW/T3 bus cycle sequencer with wait insertion and timeout abort
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              io_m,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BUS_W-1:0]  rdata,
  input  logic              ready,
  output logic              ALE,
  output logic              adbd,
  output logic [BUS_W-1:0]  addr_bus,
  output logic [BUS_W-1:0]  addr_hi,
  output logic [BUS_W-1:0]  Data_Bus_Out,
  input  logic [BUS_W-1:0]  Data_Bus_In,
  output logic              rd_n,
  output logic              wr_n,
  output logic              io_m_out
);

  bus_state_e state;
  bus_state_e next_state;

  logic              timeout;
  logic              timeout_hit;
  logic              err_pend;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic              io_m_r;
  logic [BUS_W-1:0]  wdata_r;
  logic              data_phase;

  bus_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == T1),
    .enable  (next_state == TW),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (req) next_state = T1;
      T1:   next_state = T2;
      T2:   next_state = ready ? T3 : TW;
      TW: begin
        if (ready) begin
          next_state = T3;
        end else if (timeout) begin
          next_state  = T3;
          timeout_hit = 1'b1;
        end
      end
      T3:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    data_phase = in_data_phase(state);
    busy       = (state != IDLE);
    ALE        = (state == T1);
    rd_n       = !(data_phase && !we_r);
    wr_n       = !(data_phase && we_r);
    adbd       = data_phase && we_r;
  end

  // Bus-facing fields come only from these registers so the requester may change inputs mid-cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r  <= '0;
      we_r    <= 1'b0;
      io_m_r  <= 1'b0;
      wdata_r <= '0;
    end else if ((state == IDLE) && req) begin
      addr_r  <= addr;
      we_r    <= we;
      io_m_r  <= io_m;
      wdata_r <= wdata;
    end
  end

  assign addr_bus     = addr_r[BUS_W-1:0];
  assign addr_hi      = addr_r[ADDR_W-1:BUS_W];
  assign io_m_out     = io_m_r;
  assign Data_Bus_Out = wdata_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pend <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      done <= (state == T3);
      if (state == T1) begin
        err_pend <= 1'b0;
      end else if (timeout_hit) begin
        err_pend <= 1'b1;
      end
      if (state == T3) begin
        err   <= err_pend;
        rdata <= err_pend ? RD_DATA_ON_ERR : Data_Bus_In;
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - randomized transaction-level check of bus_cycle_ctrl
module tb_bus_cycle_ctrl;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic        io_m;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic        ready;
  logic        ALE;
  logic        adbd;
  logic [7:0]  addr_bus;
  logic [7:0]  addr_hi;
  logic [7:0]  Data_Bus_Out;
  logic [7:0]  Data_Bus_In;
  logic        rd_n;
  logic        wr_n;
  logic        io_m_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_addr;
  logic        m_iom;
  logic [7:0]  m_wd;
  logic [7:0]  m_rdata;
  logic        m_err;

  bus_cycle_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .io_m         (io_m),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .ready        (ready),
    .ALE          (ALE),
    .adbd         (adbd),
    .addr_bus     (addr_bus),
    .addr_hi      (addr_hi),
    .Data_Bus_Out (Data_Bus_Out),
    .Data_Bus_In  (Data_Bus_In),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .io_m_out     (io_m_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_ale"},  32'(ALE),  32'(0));
    chk({tag, "_adbd"}, 32'(adbd), 32'(0));
    chk({tag, "_rd_n"}, 32'(rd_n), 32'(1));
    chk({tag, "_wr_n"}, 32'(wr_n), 32'(1));
    chk({tag, "_abus"}, 32'(addr_bus), 32'(m_addr[7:0]));
    chk({tag, "_ahi"},  32'(addr_hi),  32'(m_addr[15:8]));
    chk({tag, "_iom"},  32'(io_m_out), 32'(m_iom));
    chk({tag, "_dbo"},  32'(Data_Bus_Out), 32'(m_wd));
    chk({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
    chk({tag, "_err"},  32'(err), 32'(m_err));
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      req = 1'b0;
      we = 1'($urandom); io_m = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
      ready = 1'($urandom); Data_Bus_In = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("idle");
    end
  endtask

  // One transaction: n_wait is how many ready samples return 0 before the target is ready.
  task automatic run_txn(input logic t_we, input logic t_iom, input logic [15:0] t_addr,
                         input logic [7:0] t_wd, input int n_wait, input logic [7:0] t_rd);
    int tw;
    int total;
    logic e;
    logic act;
    tw    = (n_wait < LIMIT) ? n_wait : LIMIT;
    e     = (n_wait > LIMIT);
    total = 4 + tw;
    req = 1'b1; we = t_we; io_m = t_iom; addr = t_addr; wdata = t_wd;
    ready = 1'($urandom); Data_Bus_In = 8'($urandom);
    @(posedge clk);
    for (int c = 1; c <= total; c++) begin
      #1;
      req = (c == total) ? 1'b0 : 1'($urandom);
      we = 1'($urandom); io_m = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
      if (c >= 2 && c <= 2 + tw) ready = ((c - 2) >= n_wait);
      else ready = 1'($urandom);
      Data_Bus_In = (c == 3 + tw) ? t_rd : 8'($urandom);
      @(negedge clk);
      act = (c >= 2) && (c <= 3 + tw);
      chk("busy", 32'(busy), 32'(c < total));
      chk("ale",  32'(ALE),  32'(c == 1));
      chk("rd_n", 32'(rd_n), 32'(!(act && !t_we)));
      chk("wr_n", 32'(wr_n), 32'(!(act && t_we)));
      chk("adbd", 32'(adbd), 32'(act && t_we));
      chk("done", 32'(done), 32'(c == total));
      chk("strobe_excl", 32'(!rd_n && !wr_n), 32'(0));
      chk("addr_bus", 32'(addr_bus), 32'(t_addr[7:0]));
      chk("addr_hi",  32'(addr_hi),  32'(t_addr[15:8]));
      chk("io_m_out", 32'(io_m_out), 32'(t_iom));
      chk("dbo",      32'(Data_Bus_Out), 32'(t_wd));
      if (c == total) begin
        m_rdata = e ? 8'h00 : t_rd;
        m_err   = e;
      end
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("err",   32'(err),   32'(m_err));
      if (c < total) @(posedge clk);
    end
    m_addr = t_addr; m_iom = t_iom; m_wd = t_wd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; io_m = 1'b0; addr = '0; wdata = '0;
    ready = 1'b1; Data_Bus_In = '0;
    m_addr = '0; m_iom = 1'b0; m_wd = '0; m_rdata = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    run_txn(1'b0, 1'b0, 16'h12A5, 8'h00, 0, 8'h3C);
    idle(1);
    run_txn(1'b1, 1'b0, 16'h00FF, 8'h5A, 2, 8'h99);
    idle(1);
    run_txn(1'b0, 1'b1, 16'hC0DE, 8'h11, 9, 8'hAB);
    run_txn(1'b0, 1'b0, 16'h0100, 8'h00, 0, 8'h01);
    run_txn(1'b0, 1'b0, 16'h0200, 8'h00, 0, 8'h02);
    run_txn(1'b0, 1'b0, 16'h0300, 8'h00, 0, 8'h03);
    idle(2);

    req = 1'b1; we = 1'b1; io_m = 1'b0; addr = 16'hBEEF; wdata = 8'h77; ready = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_wr_n", 32'(wr_n), 32'(0));
    chk("rst_pre_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_addr = '0; m_iom = 1'b0; m_wd = '0; m_rdata = '0; m_err = 1'b0;
    chk_idle_outputs("midrst");
    rst_n = 1'b1;
    idle(6);
    run_txn(1'b1, 1'b1, 16'h4321, 8'hE7, 1, 8'h55);

    for (int i = 0; i < 150; i++) begin
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
              int'($urandom_range(0, 6)), 8'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
